imem_loader: RTL and testbench

Program loader that fills the instruction memory of the MIPS32 pipelined processor. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each completed word is written to the instruction memory's write port at successive 8-bit word addresses. While a load is in progress it holds the CPU pipeline off, and it pulses a completion flag when the load finishes.

---
 rtl/imem_loader.sv | 111 +++++++++++
 tb/tb_imem_loader.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader for the MIPS32 instruction memory: takes a length-prefixed
// byte stream, packs big-endian 32-bit words and writes them at successive addresses.
module imem_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_BYTES = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       shift;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic              accept;

  // A zero length byte stands for a completely filled memory.
  function automatic logic [CNT_W-1:0] len_to_count(input logic [7:0] len);
    if (len == 8'd0) return {1'b1, {ADDR_W{1'b0}}};
    return CNT_W'(len);
  endfunction

  assign byte_ready = (state == S_LEN) || (state == S_BYTES);
  assign accept     = byte_valid && byte_ready;
  assign we         = (state == S_WRITE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign waddr      = addr;
  assign wdata      = shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LEN;
      S_LEN: begin
        if (abort)       state_nxt = S_IDLE;
        else if (accept) state_nxt = S_BYTES;
      end
      S_BYTES: begin
        if (abort)                            state_nxt = S_IDLE;
        else if (accept && byte_idx == 2'd3)  state_nxt = S_WRITE;
      end
      // The write itself is issued in this state, so abort here still lands it.
      S_WRITE: begin
        if (abort)                             state_nxt = S_IDLE;
        else if (remaining == CNT_W'(1))       state_nxt = S_DONE;
        else                                   state_nxt = S_BYTES;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift     <= '0;
      byte_idx  <= '0;
      addr      <= '0;
      remaining <= '0;
    end else begin
      case (state)
        S_LEN: begin
          if (accept && !abort) begin
            remaining <= len_to_count(byte_data);
            addr      <= BASE_ADDR;
            byte_idx  <= 2'd0;
          end
        end
        S_BYTES: begin
          if (accept && !abort) begin
            shift    <= {shift[23:0], byte_data};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          addr      <= addr + ADDR_W'(1);
          remaining <= remaining - CNT_W'(1);
          byte_idx  <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random-gapped byte streams against a word-level
// reference model; two instances cover BASE_ADDR=0 and BASE_ADDR=0xFE.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    int          c;
  } wr_t;
  typedef wr_t wq_t[$];

  logic        clk = 1'b0;
  logic        reset, start, abort, byte_valid;
  logic [7:0]  byte_data;
  logic        br0, we0, busy0, done0;
  logic [7:0]  waddr0;
  logic [31:0] wdata0;
  logic        br1, we1, busy1, done1;
  logic [7:0]  waddr1;
  logic [31:0] wdata1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt0, done_cyc0, viol;
  wq_t log0, log1;
  wr_t mw;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(br0),
    .we(we0), .waddr(waddr0), .wdata(wdata0), .busy(busy0), .done(done0));

  imem_loader #(.ADDR_W(8), .BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(br1),
    .we(we1), .waddr(waddr1), .wdata(wdata1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Passive monitor sampling on the falling edge.
  always @(negedge clk) begin
    if (we0) begin mw.a = waddr0; mw.d = wdata0; mw.c = cyc; log0.push_back(mw); end
    if (we1) begin mw.a = waddr1; mw.d = wdata1; mw.c = cyc; log1.push_back(mw); end
    if (done0) begin done_cnt0++; done_cyc0 = cyc; end
    if (we0 && br0) viol++;
    if (we1 && br1) viol++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference: word i lands at (base+i) mod 256 and is bytes 1+4i..4+4i, MSB first.
  task automatic model(input bq_t s, input logic [7:0] base, input int nw, output wq_t e);
    wr_t w;
    e.delete();
    for (int i = 0; i < nw; i++) begin
      w.a = 8'((int'(base) + i) % 256);
      w.d = {s[1+4*i], s[2+4*i], s[3+4*i], s[4+4*i]};
      w.c = 0;
      e.push_back(w);
    end
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    done_cnt0 = 0;
    done_cyc0 = -1;
    viol      = 0;
  endtask

  task automatic do_start(input logic with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic send(input bq_t s, input int gap_pct);
    int  i = 0;
    int  guard = 0;
    logic acc;
    while (i < s.size()) begin
      @(negedge clk);
      byte_valid = ($urandom_range(99) >= gap_pct);
      byte_data  = byte_valid ? s[i] : 8'($urandom);
      acc        = byte_valid && br0;
      @(posedge clk);
      if (acc) i++;
      guard++;
      if (guard > 100 * s.size() + 100) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: got %0d accepted want %0d", i, s.size());
        break;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 40 && busy0; k++) @(negedge clk);
    n_tests++;
    if (busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: busy got %b want 0", name, busy0);
    end
  endtask

  function automatic bq_t basic_stream();
    bq_t s;
    s = '{8'h02, 8'h0C, 8'h01, 8'h00, 8'h23, 8'h04, 8'h01, 8'h00, 8'h00};
    return s;
  endfunction

  task automatic check_zero(input string name);
    n_tests++;
    if ({br0, we0, busy0, done0} !== 4'b0 || waddr0 !== 8'h00 || wdata0 !== 32'h0) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b we=%b busy=%b done=%b waddr=%h wdata=%h want all 0",
               name, br0, we0, busy0, done0, waddr0, wdata0);
    end
  endtask

  task automatic test_reset();
    bq_t s;
    reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);
    check_zero("reset_initial");
    reset = 1'b0;
    do_start(1'b0);
    s = '{8'h03, 8'hAA, 8'hBB};
    send(s, 0);
    #2 reset = 1'b1;
    #1 check_zero("reset_async");
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored: busy got %b want 0", busy0); end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: busy got %b want 0", busy0); end
  endtask

  task automatic run_basic(input string name, input int gap_pct, input logic chk_timing);
    wq_t e;
    clear_logs();
    @(negedge clk);
    start = 1'b1;
    #1;
    n_tests++;
    if (busy0 !== 1'b0) begin n_fail++; $display("FAIL %s_busy_pre: got %b want 0", name, busy0); end
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL %s_busy_rise: got %b want 1", name, busy0); end
    send(basic_stream(), gap_pct);
    wait_idle(name);
    model(basic_stream(), 8'h00, 2, e);
    n_tests++;
    if (log0.size() != e.size()) begin
      n_fail++; $display("FAIL %s_count: got %0d writes want %0d", name, log0.size(), e.size());
    end else foreach (e[i]) begin
      n_tests++;
      if (log0[i].a !== e[i].a || log0[i].d !== e[i].d) begin
        n_fail++;
        $display("FAIL %s_word%0d: got %h@%h want %h@%h", name, i, log0[i].d, log0[i].a, e[i].d, e[i].a);
      end
    end
    n_tests++;
    if (done_cnt0 != 1) begin n_fail++; $display("FAIL %s_done_count: got %0d want 1", name, done_cnt0); end
    n_tests++;
    if (log0.size() > 0 && done_cyc0 != log0[log0.size()-1].c + 1) begin
      n_fail++; $display("FAIL %s_done_timing: got cycle %0d want %0d", name, done_cyc0, log0[log0.size()-1].c + 1);
    end
    n_tests++;
    if (cyc != done_cyc0 + 1) begin
      n_fail++; $display("FAIL %s_busy_fall: busy low at cycle %0d want %0d", name, cyc, done_cyc0 + 1);
    end
    if (chk_timing && log0.size() == 2) begin
      n_tests++;
      if (log0[1].c - log0[0].c != 5) begin
        n_fail++; $display("FAIL %s_throughput: got %0d cycles want 5", name, log0[1].c - log0[0].c);
      end
    end
  endtask

  task automatic test_basic();
    run_basic("basic", 0, 1'b1);
  endtask

  task automatic test_gaps();
    bq_t s;
    wq_t e;
    int  nw;
    run_basic("gaps", 40, 1'b0);
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      nw = $urandom_range(1, 6);
      s.delete();
      s.push_back(8'(nw));
      for (int k = 0; k < 4 * nw; k++) s.push_back(8'($urandom));
      do_start(1'b0);
      send(s, 30);
      wait_idle("rand");
      model(s, 8'h00, nw, e);
      n_tests++;
      if (log0.size() != e.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", r, log0.size(), e.size());
      end else foreach (e[i]) begin
        n_tests++;
        if (log0[i].a !== e[i].a || log0[i].d !== e[i].d) begin
          n_fail++;
          $display("FAIL rand%0d_word%0d: got %h@%h want %h@%h", r, i, log0[i].d, log0[i].a, e[i].d, e[i].a);
        end
      end
      n_tests++;
      if (viol != 0) begin n_fail++; $display("FAIL rand%0d_accept_in_write: got %0d want 0", r, viol); end
    end
  endtask

  task automatic test_wrap();
    bq_t s;
    wq_t e;
    clear_logs();
    s = '{8'h03, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33};
    do_start(1'b0);
    send(s, 0);
    wait_idle("wrap");
    model(s, 8'hFE, 3, e);
    n_tests++;
    if (log1.size() != e.size()) begin
      n_fail++; $display("FAIL wrap_count: got %0d want %0d", log1.size(), e.size());
    end else foreach (e[i]) begin
      n_tests++;
      if (log1[i].a !== e[i].a || log1[i].d !== e[i].d) begin
        n_fail++;
        $display("FAIL wrap_word%0d: got %h@%h want %h@%h", i, log1[i].d, log1[i].a, e[i].d, e[i].a);
      end
    end
  endtask

  task automatic test_len0();
    bq_t s;
    wq_t e;
    clear_logs();
    s.push_back(8'h00);
    for (int k = 0; k < 1024; k++) s.push_back(8'($urandom));
    do_start(1'b0);
    send(s, 0);
    wait_idle("len0");
    model(s, 8'h00, 256, e);
    n_tests++;
    if (log0.size() != 256) begin
      n_fail++; $display("FAIL len0_count: got %0d want 256", log0.size());
    end else begin
      n_tests++;
      if (log0[255].a !== 8'hFF) begin n_fail++; $display("FAIL len0_last_addr: got %h want ff", log0[255].a); end
      foreach (e[i]) begin
        n_tests++;
        if (log0[i].a !== e[i].a || log0[i].d !== e[i].d) begin
          n_fail++;
          $display("FAIL len0_word%0d: got %h@%h want %h@%h", i, log0[i].d, log0[i].a, e[i].d, e[i].a);
        end
      end
    end
    n_tests++;
    if (done_cnt0 != 1) begin n_fail++; $display("FAIL len0_done: got %0d want 1", done_cnt0); end
  endtask

  task automatic test_abort();
    bq_t s;
    // Abort while a second word is half assembled.
    clear_logs();
    s = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
    do_start(1'b0);
    send(s, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (log0.size() != 1) begin
      n_fail++; $display("FAIL abort_count: got %0d want 1", log0.size());
    end else begin
      n_tests++;
      if (log0[0].a !== 8'h00 || log0[0].d !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL abort_word: got %h@%h want deadbeef@00", log0[0].d, log0[0].a);
      end
    end
    n_tests++;
    if (done_cnt0 != 0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL abort_state: got done=%0d busy=%b want done=0 busy=0", done_cnt0, busy0);
    end
    // Abort coinciding with the write cycle: the write still happens.
    clear_logs();
    s = '{8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    do_start(1'b0);
    send(s, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (log0.size() != 1 || (log0.size() == 1 && log0[0].d !== 32'hCAFEF00D)) begin
      n_fail++; $display("FAIL abort_in_write: got %0d writes want 1 of cafef00d", log0.size());
    end
    n_tests++;
    if (done_cnt0 != 0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL abort_write_state: got done=%0d busy=%b want done=0 busy=0", done_cnt0, busy0);
    end
    // Start and abort together in IDLE: start takes effect.
    do_start(1'b1);
    n_tests++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL start_beats_abort: busy got %b want 1", busy0); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    run_basic("reload", 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    bq_t s;
    clear_logs();
    s = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_start(1'b0);
    send(s, 0);
    #2 reset = 1'b1;
    #1 check_zero("reset_mid_outputs");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (log0.size() != 1) begin
      n_fail++; $display("FAIL reset_mid_count: got %0d want 1", log0.size());
    end
    check_zero("reset_mid_after");
    run_basic("post_reset", 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_len0();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
